// File: rtl/pin_event_capture.sv
// Pin event capture: synchronizes and debounces input pins, detects rise/fall
// edges, and latches enabled edges into sticky W1C status with a level IRQ.
module pin_event_capture #(
  parameter int unsigned Width          = 8,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [Width-1:0] pins_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_rvalid_o,
  output logic        irq_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  localparam logic [1:0] AddrLevel  = 2'd0;
  localparam logic [1:0] AddrRiseEn = 2'd1;
  localparam logic [1:0] AddrFallEn = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  logic [Width-1:0] sync1_q, sync2_q;
  logic [Width-1:0] deb_q, deb_d;
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];
  logic [Width-1:0] rise_en_q, rise_en_d;
  logic [Width-1:0] fall_en_q, fall_en_d;
  logic [Width-1:0] status_q, status_d;
  logic             irq_q, irq_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [Width-1:0] rise_c, fall_c, clr_c;
  logic             wr_c;
  logic             unused_c;

  // Word index only; byte lanes and upper write data beyond Width are don't-care.
  assign unused_c = ^{reg_wdata_i, reg_addr_i[1:0]};

  // Per-pin debounce: count consecutive disagreeing cycles, accept at the limit.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < Width; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Edge events are taken from the level about to be registered.
  assign rise_c = deb_d & ~deb_q;
  assign fall_c = ~deb_d & deb_q;

  // Register writes, sticky status (set beats W1C clear), irq and bus response.
  always_comb begin
    wr_c      = reg_req_i & reg_we_i;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_c     = '0;
    rdata_d   = '0;
    if (wr_c) begin
      case (reg_addr_i[3:2])
        AddrRiseEn: rise_en_d = reg_wdata_i[Width-1:0];
        AddrFallEn: fall_en_d = reg_wdata_i[Width-1:0];
        AddrStatus: clr_c     = reg_wdata_i[Width-1:0];
        default:    ;
      endcase
    end
    if (reg_req_i && !reg_we_i) begin
      case (reg_addr_i[3:2])
        AddrLevel:  rdata_d = 32'(deb_q);
        AddrRiseEn: rdata_d = 32'(rise_en_q);
        AddrFallEn: rdata_d = 32'(fall_en_q);
        AddrStatus: rdata_d = 32'(status_q);
        default:    rdata_d = '0;
      endcase
    end
    status_d = (status_q & ~clr_c) | (rise_c & rise_en_q) | (fall_c & fall_en_q);
    irq_d    = |status_q;
    rvalid_d = reg_req_i;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int unsigned i = 0; i < Width; i++) cnt_q[i] <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= pins_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int unsigned i = 0; i < Width; i++) cnt_q[i] <= cnt_d[i];
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;
  assign irq_o        = irq_q;

endmodule
